uart_rx_fifo_ctrl: RTL and testbench

UART_RX_FIFO_CTRL -- requirements
Module: uart_rx_fifo_ctrl

---
 rtl/uart_rx_fifo_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_fifo_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receive FIFO with sticky status, threshold/error/timeout interrupt and
// a bit-period based receive timeout.
module uart_rx_fifo_ctrl #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TO_BITS = 40
) (
  input  logic                     clock_125,
  input  logic                     rst_125,
  input  logic [11:0]              uart_cr,
  input  logic [7:0]               po_data,
  input  logic                     po_flag,
  input  logic                     ne_flag,
  input  logic                     fe_flag,
  input  logic                     pe_flag,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   rx_level,
  input  logic [$clog2(DEPTH)-1:0] rx_thr,
  output logic [7:0]               rx_sr,
  input  logic [7:0]               sr_clr,
  input  logic [2:0]               ie,
  output logic                     irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = $clog2(TO_BITS + 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(TO_BITS - 1);

  typedef enum logic [1:0] {T_IDLE, T_COUNT, T_FIRED} t_state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   level;
  logic          en_q;
  logic [6:2]    sticky;
  logic [6:2]    sticky_set;

  logic          rx_en, flush, frame_err, empty, full;
  logic          push_req, push_ok, pop, overrun;
  logic [AW-1:0] thr_eff;
  logic [13:0]   bit_period;

  t_state_t      t_state, t_state_n;
  logic [13:0]   clk_cnt, clk_cnt_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic          to_fire;

  logic          unused_ok;
  assign unused_ok = ^{uart_cr[7:1], sr_clr[7], sr_clr[1:0]};

  assign rx_en     = uart_cr[0];
  assign flush     = en_q & ~rx_en;
  assign frame_err = ne_flag | fe_flag | pe_flag;
  assign empty     = (level == '0);
  assign full      = (level == LVL_FULL);
  assign pop       = rd_en & ~empty & ~flush;
  assign push_req  = po_flag & rx_en & ~frame_err;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign push_ok   = push_req & (~full | pop);
  assign overrun   = push_req & full & ~pop;

  assign thr_eff   = (rx_thr == '0) ? AW'(1) : rx_thr;
  assign rx_level  = level;
  assign rx_sr     = {(level >= {1'b0, thr_eff}), sticky, full, ~empty};

  always_comb begin
    case (uart_cr[11:8])
      4'd0:    bit_period = 14'd13020;
      4'd1:    bit_period = 14'd6510;
      4'd2:    bit_period = 14'd3255;
      4'd3:    bit_period = 14'd2170;
      4'd4:    bit_period = 14'd1085;
      4'd5:    bit_period = 14'd125;
      4'd6:    bit_period = 14'd62;
      4'd7:    bit_period = 14'd41;
      4'd8:    bit_period = 14'd31;
      4'd9:    bit_period = 14'd25;
      4'd10:   bit_period = 14'd135;
      4'd11:   bit_period = 14'd542;
      4'd12:   bit_period = 14'd271;
      default: bit_period = 14'd0;
    endcase
  end

  always_ff @(posedge clock_125) begin
    if (push_ok && !rst_125) begin
      mem[wptr] <= po_data;
    end
  end

  always_ff @(posedge clock_125) begin
    if (rst_125) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      en_q     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      en_q     <= rx_en;
      rd_valid <= pop;
      if (pop) begin
        rd_data <= mem[rptr];
      end
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        level <= '0;
      end else begin
        if (push_ok) wptr <= wptr + 1'b1;
        if (pop)     rptr <= rptr + 1'b1;
        case ({push_ok, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
    end
  end

  assign sticky_set = {to_fire, pe_flag, fe_flag, ne_flag, overrun};

  always_ff @(posedge clock_125) begin
    if (rst_125) begin
      sticky <= '0;
      irq    <= 1'b0;
    end else begin
      // Set takes priority over a simultaneous write-1-to-clear.
      sticky <= (sticky & ~sr_clr[6:2]) | sticky_set;
      irq    <= (ie[0] & rx_sr[7]) | (ie[1] & |rx_sr[5:2]) | (ie[2] & rx_sr[6]);
    end
  end

  always_ff @(posedge clock_125) begin
    if (rst_125) begin
      t_state <= T_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      t_state <= t_state_n;
      clk_cnt <= clk_cnt_n;
      bit_cnt <= bit_cnt_n;
    end
  end

  always_comb begin
    t_state_n = t_state;
    clk_cnt_n = clk_cnt;
    bit_cnt_n = bit_cnt;
    to_fire   = 1'b0;
    if (flush) begin
      t_state_n = T_IDLE;
      clk_cnt_n = '0;
      bit_cnt_n = '0;
    end else begin
      case (t_state)
        T_IDLE: begin
          if (!empty && bit_period != '0) begin
            t_state_n = T_COUNT;
            clk_cnt_n = '0;
            bit_cnt_n = '0;
          end
        end
        T_COUNT: begin
          if (empty || bit_period == '0) begin
            t_state_n = T_IDLE;
          end else if (push_req || pop) begin
            clk_cnt_n = '0;
            bit_cnt_n = '0;
          end else if (clk_cnt >= bit_period - 14'd1) begin
            clk_cnt_n = '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt_n = '0;
              t_state_n = T_FIRED;
              to_fire   = 1'b1;
            end else begin
              bit_cnt_n = bit_cnt + 1'b1;
            end
          end else begin
            clk_cnt_n = clk_cnt + 14'd1;
          end
        end
        T_FIRED: begin
          if (push_req || pop || sr_clr[6] || !sticky[6]) begin
            t_state_n = T_IDLE;
          end
        end
        default: t_state_n = T_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Directed bench for uart_rx_fifo_ctrl: table of single-cycle vectors plus
// hand sequences for overrun, flush, threshold, error and timeout behaviour.
module tb_uart_rx_fifo_ctrl;

  logic        clock_125 = 1'b0;
  logic        rst_125;
  logic [11:0] uart_cr;
  logic [7:0]  po_data;
  logic        po_flag, ne_flag, fe_flag, pe_flag, rd_en;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [4:0]  rx_level;
  logic [3:0]  rx_thr;
  logic [7:0]  rx_sr;
  logic [7:0]  sr_clr;
  logic [2:0]  ie;
  logic        irq;

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  always #4 clock_125 = ~clock_125;

  uart_rx_fifo_ctrl #(.DEPTH(16), .TO_BITS(40)) dut (
    .clock_125 (clock_125),
    .rst_125   (rst_125),
    .uart_cr   (uart_cr),
    .po_data   (po_data),
    .po_flag   (po_flag),
    .ne_flag   (ne_flag),
    .fe_flag   (fe_flag),
    .pe_flag   (pe_flag),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rx_level  (rx_level),
    .rx_thr    (rx_thr),
    .rx_sr     (rx_sr),
    .sr_clr    (sr_clr),
    .ie        (ie),
    .irq       (irq)
  );

  typedef struct {
    logic       pf;
    logic [7:0] pd;
    logic       rd;
    logic       ne, fe, pe;
    logic [7:0] clr;
    logic [4:0] lvl;
    logic       vld;
    logic [7:0] dat;
    logic [7:0] sr;
    logic       irq;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock_125);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    po_flag = 1'b1;
    po_data = b;
    tick();
    po_flag = 1'b0;
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk({name, "_valid"}, 32'(rd_valid), 32'd1);
    chk({name, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    int unsigned n;

    //          pf  pd     rd ne fe pe clr    lvl   vld dat    sr     irq
    vt[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 8'h00, 8'h00, 1'b0};
    vt[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 8'h00, 8'h01, 1'b0};
    vt[2]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd2, 1'b0, 8'h00, 8'h81, 1'b0};
    vt[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd2, 1'b0, 8'h00, 8'h81, 1'b1};
    vt[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b1, 8'hA5, 8'h01, 1'b1};
    vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 8'h3C, 8'h00, 1'b0};
    vt[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 8'h3C, 8'h00, 1'b0};
    vt[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 5'd0, 1'b0, 8'h3C, 8'h20, 1'b0};
    vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 5'd0, 1'b0, 8'h3C, 8'h00, 1'b0};
    vt[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 8'h3C, 8'h08, 1'b0};
    vt[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 8'h3C, 8'h18, 1'b0};
    vt[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 5'd0, 1'b0, 8'h3C, 8'h00, 1'b0};
    vt[12] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 8'h3C, 8'h01, 1'b0};
    vt[13] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b1, 8'h11, 8'h01, 1'b0};
    vt[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 8'h22, 8'h00, 1'b0};

    rst_125 = 1'b1;
    uart_cr = 12'h001;
    po_data = '0;
    po_flag = 1'b0;
    ne_flag = 1'b0;
    fe_flag = 1'b0;
    pe_flag = 1'b0;
    rd_en   = 1'b0;
    rx_thr  = 4'd2;
    sr_clr  = '0;
    ie      = 3'b001;
    tick();
    tick();
    chk("rst_level", 32'(rx_level), 32'd0);
    chk("rst_sr",    32'(rx_sr),    32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data",  32'(rd_data),  32'd0);
    chk("rst_irq",   32'(irq),      32'd0);
    rst_125 = 1'b0;

    for (int i = 0; i < 15; i++) begin
      po_flag = vt[i].pf;
      po_data = vt[i].pd;
      rd_en   = vt[i].rd;
      ne_flag = vt[i].ne;
      fe_flag = vt[i].fe;
      pe_flag = vt[i].pe;
      sr_clr  = vt[i].clr;
      tick();
      chk($sformatf("vec%0d_level", i), 32'(rx_level), 32'(vt[i].lvl));
      chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vt[i].vld));
      chk($sformatf("vec%0d_data", i),  32'(rd_data),  32'(vt[i].dat));
      chk($sformatf("vec%0d_sr", i),    32'(rx_sr),    32'(vt[i].sr));
      chk($sformatf("vec%0d_irq", i),   32'(irq),      32'(vt[i].irq));
    end
    po_flag = 1'b0; rd_en = 1'b0; ne_flag = 1'b0; fe_flag = 1'b0; pe_flag = 1'b0; sr_clr = '0;

    // Overrun: 17 pushes into 16 entries, then push+pop on a full FIFO.
    rx_thr = 4'd15;
    ie     = 3'b000;
    for (int i = 0; i < 17; i++) push(8'(i * 7 + 3));
    chk("ovr_level", 32'(rx_level), 32'd16);
    chk("ovr_full",  32'(rx_sr[1]), 32'd1);
    chk("ovr_flag",  32'(rx_sr[2]), 32'd1);
    sr_clr = 8'h04;
    tick();
    sr_clr = '0;
    chk("ovr_clr", 32'(rx_sr[2]), 32'd0);
    po_flag = 1'b1; po_data = 8'hEE; rd_en = 1'b1;
    tick();
    po_flag = 1'b0; rd_en = 1'b0;
    chk("fullrw_valid", 32'(rd_valid), 32'd1);
    chk("fullrw_data",  32'(rd_data),  32'd3);
    chk("fullrw_level", 32'(rx_level), 32'd16);
    chk("fullrw_ovr",   32'(rx_sr[2]), 32'd0);
    for (int i = 1; i < 16; i++) pop_chk($sformatf("drain%0d", i), 8'(i * 7 + 3));
    pop_chk("drain_last", 8'hEE);
    chk("drain_level", 32'(rx_level), 32'd0);
    chk("drain_empty", 32'(rx_sr[0]), 32'd0);

    // Threshold interrupt.
    rx_thr = 4'd4;
    ie     = 3'b001;
    for (int i = 0; i < 4; i++) push(8'(8'h40 + i));
    chk("thr_sr7", 32'(rx_sr[7]), 32'd1);
    tick();
    chk("thr_irq", 32'(irq), 32'd1);
    pop_chk("thr_pop", 8'h40);
    chk("thr_sr7_low", 32'(rx_sr[7]), 32'd0);
    tick();
    chk("thr_irq_low", 32'(irq), 32'd0);
    for (int i = 1; i < 4; i++) pop_chk($sformatf("thr_drain%0d", i), 8'(8'h40 + i));

    // Parity error set beats a simultaneous clear.
    ie = 3'b010;
    pe_flag = 1'b1; sr_clr = 8'h20;
    tick();
    pe_flag = 1'b0; sr_clr = '0;
    chk("pe_setwins", 32'(rx_sr[5]), 32'd1);
    tick();
    chk("pe_irq", 32'(irq), 32'd1);
    sr_clr = 8'h20;
    tick();
    sr_clr = '0;
    chk("pe_clr", 32'(rx_sr[5]), 32'd0);
    tick();
    chk("pe_irq_low", 32'(irq), 32'd0);

    // Flush on receiver disable keeps sticky bits; disabled receiver ignores po_flag.
    ie = 3'b000;
    push(8'h01);
    push(8'h02);
    ne_flag = 1'b1;
    tick();
    ne_flag = 1'b0;
    uart_cr = 12'h000;
    tick();
    chk("flush_level", 32'(rx_level), 32'd0);
    chk("flush_sticky", 32'(rx_sr[3]), 32'd1);
    push(8'h77);
    chk("dis_level", 32'(rx_level), 32'd0);
    uart_cr = 12'h001;
    sr_clr  = 8'hFF;
    rd_en   = 1'b1;
    tick();
    sr_clr = '0;
    rd_en  = 1'b0;
    chk("empty_rd_valid", 32'(rd_valid), 32'd0);
    chk("flush_sr_clr", 32'(rx_sr), 32'd0);

    // Receive timeout at 25 clocks/bit * 40 bits.
    uart_cr = 12'h901;
    ie      = 3'b100;
    push(8'h5A);
    n = 0;
    for (int k = 1; k <= 1100; k++) begin
      tick();
      if (rx_sr[6]) begin
        n = k;
        break;
      end
    end
    n_run++;
    if (n < 998 || n > 1002) begin
      n_fail++;
      $display("FAIL to_cycles: got %0d expected 998..1002 (0 = never fired)", n);
    end
    tick();
    chk("to_irq", 32'(irq), 32'd1);
    sr_clr = 8'h40;
    tick();
    sr_clr = '0;
    chk("to_clr", 32'(rx_sr[6]), 32'd0);
    tick();
    chk("to_irq_low", 32'(irq), 32'd0);
    uart_cr = 12'hD01;
    repeat (1100) tick();
    chk("to_disabled", 32'(rx_sr[6]), 32'd0);
    pop_chk("to_pop", 8'h5A);

    // Reset mid-operation overrides a simultaneous push.
    uart_cr = 12'h001;
    push(8'h99);
    pe_flag = 1'b1;
    tick();
    pe_flag = 1'b0;
    rst_125 = 1'b1; po_flag = 1'b1; po_data = 8'h55;
    tick();
    rst_125 = 1'b0; po_flag = 1'b0;
    chk("midrst_level", 32'(rx_level), 32'd0);
    chk("midrst_sr",    32'(rx_sr),    32'd0);
    chk("midrst_data",  32'(rd_data),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
